// File: rtl/mem_traffic_gen.sv
// Memory traffic generator: writes a pattern over NUM_WORDS words, then reads
// the same words back and checks them against the pattern.
module mem_traffic_gen #(
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned ADDR_STEP = 8,
    parameter int unsigned PATTERN   = 0,
    parameter int unsigned LOOP      = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              calib_done_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic [ADDR_W-1:0] app_addr_o,
    output logic [2:0]        app_cmd_o,
    output logic              app_en_o,
    input  logic              app_rdy_i,
    output logic [DATA_W-1:0] app_wdf_data_o,
    output logic              app_wdf_wren_o,
    output logic              app_wdf_end_o,
    input  logic              app_wdf_rdy_i,
    input  logic [DATA_W-1:0] app_rd_data_i,
    input  logic              app_rd_data_valid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [15:0]       err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic [15:0]       pass_cnt_o
);

    localparam int unsigned LANES = DATA_W / 32;
    localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);

    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0]  ALL_IDX  = IDX_W'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);
    localparam logic [2:0]        CMD_WR   = 3'b000;
    localparam logic [2:0]        CMD_RD   = 3'b001;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;          // word being issued
    logic [IDX_W-1:0]  ret_idx_q, ret_idx_d;  // word expected on the return path
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;

    logic [ADDR_W-1:0] addr_d;
    logic [2:0]        cmd_d;
    logic              en_d;
    logic [DATA_W-1:0] wdata_d;
    logic              wren_d;
    logic              wend_d;
    logic              busy_d;
    logic              done_d;
    logic              pass_d;
    logic [15:0]       err_d;
    logic [ADDR_W-1:0] first_d;
    logic [15:0]       pcnt_d;

    logic              cmd_acc;
    logic              dat_acc;
    logic              cmd_clear;
    logic              dat_clear;
    logic              load;
    logic [ADDR_W-1:0] load_base;

    // Lane k of word idx is idx+k, optionally inverted
    function automatic logic [DATA_W-1:0] pattern_word(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] w;
        logic [31:0]       lane;
        w = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            lane = 32'(idx) + 32'(k);
            w[k*32 +: 32] = (PATTERN != 0) ? ~lane : lane;
        end
        return w;
    endfunction

    // Next-state, handshake tracking, read-back checking and output values
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        ret_idx_d  = ret_idx_q;
        ret_addr_d = ret_addr_q;
        addr_d     = app_addr_o;
        cmd_d      = app_cmd_o;
        en_d       = app_en_o;
        wdata_d    = app_wdf_data_o;
        wren_d     = app_wdf_wren_o;
        wend_d     = app_wdf_end_o;
        done_d     = done_o;
        pass_d     = pass_o;
        err_d      = err_cnt_o;
        first_d    = first_err_addr_o;
        pcnt_d     = pass_cnt_o;
        load       = 1'b0;
        load_base  = base_q;

        cmd_acc   = app_en_o & app_rdy_i;
        dat_acc   = app_wdf_wren_o & app_wdf_rdy_i;
        cmd_clear = ~app_en_o | cmd_acc;
        dat_clear = ~app_wdf_wren_o | dat_acc;

        // Returned data is checked in order, independent of command issue
        if (((state_q == READ) || (state_q == DRAIN)) && app_rd_data_valid_i
            && (ret_idx_q < ALL_IDX)) begin
            if (app_rd_data_i != pattern_word(ret_idx_q)) begin
                if (err_cnt_o == 16'd0) begin
                    first_d = ret_addr_q;
                end
                if (err_cnt_o != 16'hFFFF) begin
                    err_d = err_cnt_o + 16'd1;
                end
            end
            ret_idx_d  = ret_idx_q + IDX_ONE;
            ret_addr_d = ret_addr_q + STEP;
        end

        case (state_q)
            IDLE: begin
                if (start_i && calib_done_i) begin
                    load      = 1'b1;
                    load_base = base_addr_i;
                    err_d     = '0;
                    first_d   = '0;
                end
            end
            WRITE: begin
                if (cmd_clear && dat_clear) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = READ;
                        idx_d   = '0;
                        addr_d  = base_q;
                        cmd_d   = CMD_RD;
                        en_d    = 1'b1;
                        wren_d  = 1'b0;
                        wend_d  = 1'b0;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        addr_d  = app_addr_o + STEP;
                        en_d    = 1'b1;
                        wren_d  = 1'b1;
                        wend_d  = 1'b1;
                        wdata_d = pattern_word(idx_q + IDX_ONE);
                    end
                end else begin
                    en_d   = ~cmd_clear;
                    wren_d = ~dat_clear;
                    wend_d = ~dat_clear;
                end
            end
            READ: begin
                if (cmd_acc) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                        en_d    = 1'b0;
                    end else begin
                        idx_d  = idx_q + IDX_ONE;
                        addr_d = app_addr_o + STEP;
                    end
                end
            end
            DRAIN: begin
                if (ret_idx_d == ALL_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start_i && calib_done_i) begin
                    load      = 1'b1;
                    load_base = base_addr_i;
                    err_d     = '0;
                    first_d   = '0;
                end else if (LOOP != 0) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pass bookkeeping happens once, on the cycle DONE is entered
        if ((state_d == DONE) && (state_q != DONE)) begin
            done_d = 1'b1;
            pass_d = (err_d == 16'd0);
            pcnt_d = pass_cnt_o + 16'd1;
        end

        // Start (or restart) a write phase from word 0
        if (load) begin
            state_d    = WRITE;
            base_d     = load_base;
            idx_d      = '0;
            ret_idx_d  = '0;
            ret_addr_d = load_base;
            addr_d     = load_base;
            cmd_d      = CMD_WR;
            en_d       = 1'b1;
            wdata_d    = pattern_word('0);
            wren_d     = 1'b1;
            wend_d     = 1'b1;
            done_d     = 1'b0;
        end

        busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q          <= IDLE;
            base_q           <= '0;
            idx_q            <= '0;
            ret_idx_q        <= '0;
            ret_addr_q       <= '0;
            app_addr_o       <= '0;
            app_cmd_o        <= '0;
            app_en_o         <= 1'b0;
            app_wdf_data_o   <= '0;
            app_wdf_wren_o   <= 1'b0;
            app_wdf_end_o    <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            pass_cnt_o       <= '0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            idx_q            <= idx_d;
            ret_idx_q        <= ret_idx_d;
            ret_addr_q       <= ret_addr_d;
            app_addr_o       <= addr_d;
            app_cmd_o        <= cmd_d;
            app_en_o         <= en_d;
            app_wdf_data_o   <= wdata_d;
            app_wdf_wren_o   <= wren_d;
            app_wdf_end_o    <= wend_d;
            busy_o           <= busy_d;
            done_o           <= done_d;
            pass_o           <= pass_d;
            err_cnt_o        <= err_d;
            first_err_addr_o <= first_d;
            pass_cnt_o       <= pcnt_d;
        end
    end

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Bench for mem_traffic_gen: a scoreboarded memory model around one instance,
// plus a free-running LOOP instance with an inverted pattern.
`timescale 1ns/1ps
module tb_mem_traffic_gen;

    localparam int unsigned AW   = 28;
    localparam int unsigned DW   = 64;
    localparam int unsigned NW   = 4;
    localparam int unsigned STEP = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic          rst = 1'b0, start = 1'b0, calib = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] addr;
    logic [2:0]    cmd;
    logic          en, rdy, wren, wend, wrdy, rvalid;
    logic [DW-1:0] wdata, rdata;
    logic          busy, done, pass;
    logic [15:0]   err, pcnt;
    logic [AW-1:0] first_err;

    // loop instance
    logic          l_rst = 1'b0, l_start = 1'b0;
    logic [AW-1:0] l_base = '0;
    logic [AW-1:0] l_addr;
    logic [2:0]    l_cmd;
    logic          l_en, l_wren, l_wend, l_rvalid;
    logic [DW-1:0] l_wdata, l_rdata;
    logic          l_busy, l_done, l_pass;
    logic [15:0]   l_err, l_pcnt;
    logic [AW-1:0] l_first;

    int tests = 0;
    int fails = 0;

    mem_traffic_gen #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .ADDR_STEP(STEP), .PATTERN(0), .LOOP(0)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .calib_done_i(calib), .base_addr_i(base),
        .app_addr_o(addr), .app_cmd_o(cmd), .app_en_o(en), .app_rdy_i(rdy),
        .app_wdf_data_o(wdata), .app_wdf_wren_o(wren), .app_wdf_end_o(wend), .app_wdf_rdy_i(wrdy),
        .app_rd_data_i(rdata), .app_rd_data_valid_i(rvalid),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err),
        .first_err_addr_o(first_err), .pass_cnt_o(pcnt)
    );

    mem_traffic_gen #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .ADDR_STEP(STEP), .PATTERN(1), .LOOP(1)
    ) u_loop (
        .clk_i(clk), .rst_i(l_rst), .start_i(l_start), .calib_done_i(1'b1), .base_addr_i(l_base),
        .app_addr_o(l_addr), .app_cmd_o(l_cmd), .app_en_o(l_en), .app_rdy_i(1'b1),
        .app_wdf_data_o(l_wdata), .app_wdf_wren_o(l_wren), .app_wdf_end_o(l_wend), .app_wdf_rdy_i(1'b1),
        .app_rd_data_i(l_rdata), .app_rd_data_valid_i(l_rvalid),
        .busy_o(l_busy), .done_o(l_done), .pass_o(l_pass), .err_cnt_o(l_err),
        .first_err_addr_o(l_first), .pass_cnt_o(l_pcnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference pattern: lane0 = i, lane1 = i+1, optionally inverted
    function automatic logic [DW-1:0] pat(input int unsigned i, input bit inv);
        logic [31:0]   l0;
        logic [31:0]   l1;
        logic [DW-1:0] w;
        l0 = 32'(i);
        l1 = 32'(i + 1);
        w  = {l1, l0};
        return inv ? ~w : w;
    endfunction

    // scoreboard and memory model state
    logic [AW-1:0] exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    logic [AW-1:0] exp_ra[$];
    logic [DW-1:0] rd_pipe[$];
    logic [AW-1:0] mw_addr[$];
    logic [DW-1:0] mw_data[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    int            stall_left = 0;
    bit            rnd = 1'b0;
    logic [3:0]    corrupt = '0;
    logic [AW-1:0] cur_base = '0;
    int            junk_cycles = 0;
    int            wcmd_n = 0, wdat_n = 0, rcmd_n = 0, cmd_at_first_dat = -1;
    bit            hold_pend = 1'b0, cmd_pend = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic [AW-1:0] hold_addr = '0;
    logic [2:0]    hold_cmd = '0;
    int            exp_pass_cnt = 0;

    // Memory model for the main instance: back-pressure, stores writes, returns reads
    initial begin : mem_model
        logic [DW-1:0] d;
        logic [AW-1:0] off;
        int            wi;
        rdy = 1'b0; wrdy = 1'b0; rvalid = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            if (junk_cycles > 0) begin
                rvalid = 1'b1; rdata = 64'hDEAD_BEEF_0BAD_F00D; junk_cycles--;
            end else if (rd_pipe.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
                rvalid = 1'b1; rdata = rd_pipe.pop_front();
            end else begin
                rvalid = 1'b0; rdata = '0;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_left > 0 && wren) begin
                wrdy = 1'b0; stall_left--;
            end else begin
                wrdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (hold_pend) begin
                chk("wren_held", 64'(wren), 64'(1));
                chk("wdata_held", 64'(wdata), 64'(hold_data));
            end
            if (cmd_pend) begin
                chk("en_held", 64'(en), 64'(1));
                chk("addr_held", 64'(addr), 64'(hold_addr));
                chk("cmd_held", 64'(cmd), 64'(hold_cmd));
            end
            if (en && rdy) begin
                if (cmd == 3'b000) begin
                    wcmd_n++;
                    if (exp_wa.size() == 0) chk("wr_cmd_unexpected", 64'(addr), 64'(0));
                    else chk("wr_addr", 64'(addr), 64'(exp_wa.pop_front()));
                    mw_addr.push_back(addr);
                end else if (cmd == 3'b001) begin
                    rcmd_n++;
                    if (exp_ra.size() == 0) chk("rd_cmd_unexpected", 64'(addr), 64'(0));
                    else chk("rd_addr", 64'(addr), 64'(exp_ra.pop_front()));
                    d   = mem.exists(addr) ? mem[addr] : '0;
                    off = addr - cur_base;
                    wi  = int'(off >> 3);
                    if (wi < 4 && corrupt[2'(wi)]) d[0] = ~d[0];
                    rd_pipe.push_back(d);
                end else begin
                    chk("cmd_code", 64'(cmd), 64'(0));
                end
            end
            if (wren && wrdy) begin
                wdat_n++;
                if (wdat_n == 1) cmd_at_first_dat = wcmd_n;
                chk("wdf_end", 64'(wend), 64'(1));
                if (exp_wd.size() == 0) chk("wr_data_unexpected", 64'(wdata), 64'(0));
                else chk("wr_data", 64'(wdata), 64'(exp_wd.pop_front()));
                mw_data.push_back(wdata);
            end
            while (mw_addr.size() > 0 && mw_data.size() > 0)
                mem[mw_addr.pop_front()] = mw_data.pop_front();
            hold_pend = wren && !wrdy;
            hold_data = wdata;
            cmd_pend  = en && !rdy;
            hold_addr = addr;
            hold_cmd  = cmd;
        end
    end

    // Ideal memory for the loop instance: returns the reference pattern in order
    initial begin : loop_model
        bit            pend;
        logic [DW-1:0] pdata;
        int            cnt;
        pend = 1'b0; pdata = '0; cnt = 0;
        l_rvalid = 1'b0; l_rdata = '0;
        forever begin
            @(negedge clk);
            l_rvalid = pend;
            l_rdata  = pdata;
            if (l_en && l_cmd == 3'b001) begin
                pend  = 1'b1;
                pdata = pat(cnt % 4, 1'b1);
                cnt++;
            end else begin
                pend = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [AW-1:0] base;
        int            stall;
        bit            rnd;
        logic [3:0]    corr;
        bit            mid_start;
        bit            drop_calib;
        int            err;
        logic [AW-1:0] first;
        bit            pass;
    } vec_t;

    task automatic run_pass(input vec_t v, input string tag);
        int            cyc;
        logic [AW-1:0] a;
        @(negedge clk); #1;
        stall_left = v.stall; rnd = v.rnd; corrupt = v.corr; cur_base = v.base;
        wcmd_n = 0; wdat_n = 0; rcmd_n = 0; cmd_at_first_dat = -1;
        mem.delete();
        for (int i = 0; i < int'(NW); i++) begin
            a = v.base + AW'(i * int'(STEP));
            exp_wa.push_back(a);
            exp_wd.push_back(pat(i, 1'b0));
            exp_ra.push_back(a);
        end
        calib = 1'b1; start = 1'b1; base = v.base;
        @(negedge clk); #1;
        start = 1'b0; base = ~v.base;
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        chk({tag, "_done_cleared"}, 64'(done), 64'(0));
        if (v.drop_calib) calib = 1'b0;
        if (v.mid_start) begin
            @(negedge clk); #1;
            start = 1'b1; base = v.base ^ 28'h0F0_0000;
            @(negedge clk); #1;
            start = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        chk({tag, "_done"}, 64'(done), 64'(1));
        exp_pass_cnt++;
        chk({tag, "_pass"}, 64'(pass), 64'(v.pass));
        chk({tag, "_err_cnt"}, 64'(err), 64'(v.err));
        chk({tag, "_first_err"}, 64'(first_err), 64'(v.first));
        chk({tag, "_pass_cnt"}, 64'(pcnt), 64'(exp_pass_cnt));
        chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
        chk({tag, "_writes"}, 64'(wdat_n), 64'(NW));
        chk({tag, "_reads"}, 64'(rcmd_n), 64'(NW));
        chk({tag, "_sb_left"}, 64'(exp_wa.size() + exp_wd.size() + exp_ra.size()), 64'(0));
        if (v.stall > 0) chk({tag, "_cmd_once_before_data"}, 64'(cmd_at_first_dat), 64'(1));
        calib = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, 64'(en), 64'(0));
        chk({tag, "_wren_end"}, 64'({wren, wend}), 64'(0));
        chk({tag, "_busy_done_pass"}, 64'({busy, done, pass}), 64'(0));
        chk({tag, "_err_first"}, 64'({err, first_err}), 64'(0));
        chk({tag, "_pass_cnt"}, 64'(pcnt), 64'(0));
        chk({tag, "_addr_cmd"}, 64'({addr, cmd}), 64'(0));
        chk({tag, "_wdata"}, 64'(wdata), 64'(0));
    endtask

    initial begin : main
        vec_t vecs[6];
        int   cyc, pulses, viol;
        bit   prev_done;

        //           base           stall rnd corr     mid   dropc err first          pass
        vecs[0] = '{28'h0000100,    0,    0,  4'b0000, 1'b0, 1'b0, 0, 28'h0,         1'b1};
        vecs[1] = '{28'h0000100,    3,    0,  4'b0000, 1'b0, 1'b0, 0, 28'h0,         1'b1};
        vecs[2] = '{28'h0000200,    0,    0,  4'b1100, 1'b0, 1'b0, 2, 28'h0000210,   1'b0};
        vecs[3] = '{28'hFFFFFF8,    0,    0,  4'b0000, 1'b1, 1'b1, 0, 28'h0,         1'b1};
        vecs[4] = '{28'h0ABC000,    0,    1,  4'b0001, 1'b0, 1'b0, 1, 28'h0ABC000,   1'b0};
        vecs[5] = '{28'hFFFFFF0,    2,    1,  4'b1010, 1'b1, 1'b0, 2, 28'hFFFFFF8,   1'b0};

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1; l_rst = 1'b1;

        // start without calibration is ignored
        @(negedge clk); #1;
        start = 1'b1; calib = 1'b0; base = 28'h0000040;
        @(negedge clk); #1;
        start = 1'b0;
        chk("start_no_calib", 64'(busy), 64'(0));

        for (int i = 0; i < 6; i++) begin
            run_pass(vecs[i], $sformatf("vec%0d", i));
        end

        // read-data valid in DONE must not be compared
        @(negedge clk); #1;
        junk_cycles = 3;
        repeat (5) @(negedge clk);
        #1;
        chk("junk_in_done_err", 64'(err), 64'(2));
        chk("junk_in_done_held", 64'(done), 64'(1));

        // reset in the middle of READ, then a fresh pass
        @(negedge clk); #1;
        cur_base = 28'h0000500; rnd = 1'b0; corrupt = '0; stall_left = 0;
        mem.delete();
        for (int i = 0; i < int'(NW); i++) begin
            exp_wa.push_back(28'h0000500 + AW'(i * int'(STEP)));
            exp_wd.push_back(pat(i, 1'b0));
            exp_ra.push_back(28'h0000500 + AW'(i * int'(STEP)));
        end
        start = 1'b1; base = 28'h0000500;
        @(negedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(en && cmd == 3'b001) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_read_reached", 64'(en && cmd == 3'b001), 64'(1));
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("rst_mid_read");
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
        rd_pipe.delete(); mw_addr.delete(); mw_data.delete();
        exp_pass_cnt = 0;
        rst = 1'b1;
        run_pass('{28'h0000600, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 0, 28'h0, 1'b1}, "after_rst");

        // LOOP instance: three passes back to back
        @(negedge clk); #1;
        l_start = 1'b1; l_base = 28'h0000040;
        @(negedge clk); #1;
        l_start = 1'b0;
        pulses = 0; viol = 0; cyc = 0; prev_done = 1'b0;
        while (pulses < 3 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (l_done) begin
                pulses++;
                if (prev_done) viol++;
                if (l_busy) viol++;
                if (pulses == 3) begin
                    chk("loop_pass_cnt", 64'(l_pcnt), 64'(3));
                    chk("loop_pass", 64'(l_pass), 64'(1));
                    chk("loop_err", 64'(l_err), 64'(0));
                end
            end else if (!l_busy) begin
                viol++;
            end
            prev_done = l_done;
        end
        chk("loop_pulses", 64'(pulses), 64'(3));
        chk("loop_shape_violations", 64'(viol), 64'(0));
        #1;
        l_rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
